// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS core memory arbiter: FSM state encoding,
// the Avalon byte-enable used for every transfer, and the default watchdog limit.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DATA,
        EXEC,
        ERROR
    } state_t;

    localparam logic [3:0] AVM_BYTEENABLE_ALL     = 4'b1111;
    localparam int         TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/mips_cpu_mem_watchdog.sv
// Counts consecutive waitrequest cycles of the current Avalon transfer and
// flags the cycle on which the tolerated number of stalls is used up.
module mips_cpu_mem_watchdog
    import mips_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic waitrequest,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (strobe && !waitrequest) begin
            count <= '0;
        end else if (strobe && waitrequest) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires on the last tolerated stall so the FSM leaves on that same edge.
    assign timeout = strobe && waitrequest && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Multicycle MIPS core to Avalon-MM bridge: FETCH, optional DATA access, EXEC pulse.
// Define MIPS_CPU_MEM_ARBITER_TIMEOUT_EN to enable the waitrequest watchdog and ERROR state.
module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] cpu_instr_address,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic        cpu_clk_enable,
    output logic [31:0] cpu_instr_readdata,
    output logic [31:0] cpu_data_readdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        bus_error
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    state_t state_next;
    logic   data_read_eff;
    logic   xfer_done;
    logic   timeout;

    // A store wins when the decoder raises both strobes.
    assign data_read_eff = cpu_data_read & ~cpu_data_write;
    assign xfer_done     = (avm_read | avm_write) & ~avm_waitrequest;

    always_comb begin
        state_next  = state;
        avm_read    = 1'b0;
        avm_write   = 1'b0;
        avm_address = cpu_instr_address;
        case (state)
            IDLE: begin
                if (cpu_active) state_next = FETCH;
            end
            FETCH: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) state_next = DATA;
            end
            DATA: begin
                avm_address = cpu_data_address;
                avm_write   = cpu_data_write;
                avm_read    = data_read_eff;
                if (!(cpu_data_read || cpu_data_write) || !avm_waitrequest) state_next = EXEC;
            end
            EXEC: begin
                state_next = cpu_active ? FETCH : IDLE;
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (timeout) state_next = ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cpu_instr_readdata <= '0;
            cpu_data_readdata  <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && xfer_done) cpu_instr_readdata <= avm_readdata;
            if (state == DATA && avm_read && !avm_waitrequest) cpu_data_readdata <= avm_readdata;
        end
    end

    assign cpu_clk_enable = (state == EXEC);
    assign avm_writedata  = cpu_data_writedata;
    assign avm_byteenable = AVM_BYTEENABLE_ALL;

`ifdef MIPS_CPU_MEM_ARBITER_TIMEOUT_EN
    mips_cpu_mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .strobe     (avm_read | avm_write),
        .waitrequest(avm_waitrequest),
        .timeout    (timeout)
    );
    assign bus_error = (state == ERROR);
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Bench for mips_cpu_mem_arbiter: scoreboarded Avalon transfers plus per-scenario latency checks.
module tb_mips_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_active = 1'b0;
    logic [31:0] cpu_instr_address = '0;
    logic [31:0] cpu_data_address = '0;
    logic        cpu_data_read = 1'b0;
    logic        cpu_data_write = 1'b0;
    logic [31:0] cpu_data_writedata = '0;
    logic        cpu_clk_enable;
    logic [31:0] cpu_instr_readdata;
    logic [31:0] cpu_data_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        bus_error;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_e;
    int   tests = 0;
    int   fails = 0;

    mips_cpu_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_active        (cpu_active),
        .cpu_instr_address (cpu_instr_address),
        .cpu_data_address  (cpu_data_address),
        .cpu_data_read     (cpu_data_read),
        .cpu_data_write    (cpu_data_write),
        .cpu_data_writedata(cpu_data_writedata),
        .cpu_clk_enable    (cpu_clk_enable),
        .cpu_instr_readdata(cpu_instr_readdata),
        .cpu_data_readdata (cpu_data_readdata),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .bus_error         (bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Every completed Avalon transfer is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset && (avm_read || avm_write)) begin
            tests++;
            if (avm_read && avm_write) begin
                fails++;
                $display("FAIL strobe_exclusive read=%0b write=%0b required not both high", avm_read, avm_write);
            end
            if (!avm_waitrequest) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bus_unexpected addr=%h rd=%0b wr=%0b required no transfer",
                             avm_address, avm_read, avm_write);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (avm_read !== mon_e.rd || avm_write !== mon_e.wr || avm_address !== mon_e.addr ||
                        avm_byteenable !== 4'b1111 || (mon_e.wr && avm_writedata !== mon_e.wdata)) begin
                        fails++;
                        $display("FAIL bus_txn got rd=%0b wr=%0b addr=%h wd=%h be=%b required rd=%0b wr=%0b addr=%h wd=%h be=1111",
                                 avm_read, avm_write, avm_address, avm_writedata, avm_byteenable,
                                 mon_e.rd, mon_e.wr, mon_e.addr, mon_e.wdata);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plays core plus memory for one instruction; returns the cycle index of the enable pulse.
    task automatic run_instr(input logic [31:0] iaddr, input logic [31:0] instr,
                             input logic rd, input logic wr, input logic [31:0] daddr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int fwaits, input int dwaits, input logic keep,
                             output int cycles);
        int   phase;
        int   fw;
        int   dw;
        bit   done;
        txn_t t;
        fw = fwaits;
        dw = dwaits;
        phase = 0;
        cycles = 0;
        done = 0;
        cpu_instr_address = iaddr;
        cpu_data_read = 1'b0;
        cpu_data_write = 1'b0;
        avm_waitrequest = (fw > 0);
        avm_readdata = instr;
        t.rd = 1'b1; t.wr = 1'b0; t.addr = iaddr; t.wdata = '0;
        exp_q.push_back(t);
        cpu_active = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            cycles++;
            if (cpu_clk_enable) begin
                done = 1;
            end else begin
                if (phase == 1) begin
                    cpu_data_read = rd;
                    cpu_data_write = wr;
                    cpu_data_address = daddr;
                    cpu_data_writedata = wdata;
                    cpu_active = keep;
                    if (rd || wr) begin
                        t.rd = rd & ~wr; t.wr = wr; t.addr = daddr; t.wdata = wdata;
                        exp_q.push_back(t);
                    end
                    phase = 2;
                    #1;
                end
                if (phase == 0 && avm_read) begin
                    avm_readdata = instr;
                    if (fw > 0) begin
                        avm_waitrequest = 1'b1;
                        fw--;
                    end else begin
                        avm_waitrequest = 1'b0;
                        phase = 1;
                    end
                end else if (phase == 2 && (avm_read || avm_write)) begin
                    avm_readdata = rdata;
                    if (dw > 0) begin
                        avm_waitrequest = 1'b1;
                        dw--;
                    end else begin
                        avm_waitrequest = 1'b0;
                    end
                end
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL run_instr_enable no cpu_clk_enable within 50 cycles for instr at %h", iaddr);
            cycles = -1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++;
        if ({cpu_clk_enable, avm_read, avm_write, bus_error} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_strobes en/rd/wr/err=%b required 0000",
                     {cpu_clk_enable, avm_read, avm_write, bus_error});
        end
        tests++;
        if (cpu_instr_readdata !== 32'h0 || cpu_data_readdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_readdata instr=%h data=%h required 0", cpu_instr_readdata, cpu_data_readdata);
        end
        reset = 1'b0;
        step();
        tests++;
        if (avm_read !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle avm_read=%0b required 0 while cpu_active low", avm_read);
        end
    endtask

    task automatic test_addu();
        int c;
        run_instr(32'hBFC0_0000, 32'h0085_1021, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, c);
        tests++;
        if (c !== 3) begin
            fails++;
            $display("FAIL addu_latency enable_cycle=%0d required 3", c);
        end
        tests++;
        if (cpu_instr_readdata !== 32'h0085_1021) begin
            fails++;
            $display("FAIL addu_instr got=%h required 00851021", cpu_instr_readdata);
        end
        step();
        tests++;
        if (cpu_clk_enable !== 1'b0) begin
            fails++;
            $display("FAIL addu_pulse_width enable=%0b required 0 after one cycle", cpu_clk_enable);
        end
    endtask

    task automatic test_lw_wait();
        int c;
        run_instr(32'hBFC0_0004, 32'h8C82_0000, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 0, 2, 1'b0, c);
        tests++;
        if (c !== 5) begin
            fails++;
            $display("FAIL lw_latency enable_cycle=%0d required 5", c);
        end
        tests++;
        if (cpu_data_readdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL lw_data got=%h required deadbeef", cpu_data_readdata);
        end
        step();
    endtask

    task automatic test_sw();
        int c;
        run_instr(32'hBFC0_0008, 32'hAC85_1000, 1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 32'h0, 0, 0, 1'b0, c);
        tests++;
        if (c !== 3) begin
            fails++;
            $display("FAIL sw_latency enable_cycle=%0d required 3", c);
        end
        tests++;
        if (cpu_data_readdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL sw_keeps_load_data got=%h required deadbeef", cpu_data_readdata);
        end
        step();
    endtask

    task automatic test_rw_priority();
        int c;
        run_instr(32'hBFC0_000C, 32'hAC86_3000, 1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 32'h1111_1111, 0, 0, 1'b0, c);
        tests++;
        if (c !== 3) begin
            fails++;
            $display("FAIL rw_latency enable_cycle=%0d required 3", c);
        end
        tests++;
        if (cpu_data_readdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL rw_read_ignored data=%h required deadbeef", cpu_data_readdata);
        end
        step();
    endtask

    task automatic test_fetch_wait();
        int c;
        run_instr(32'hBFC0_0010, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3, 0, 1'b0, c);
        tests++;
        if (c !== 6) begin
            fails++;
            $display("FAIL fetch_wait_latency enable_cycle=%0d required 6", c);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int c1;
        int c2;
        run_instr(32'hBFC0_0020, 32'h8C83_0000, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 32'h0A0B_0C0D, 0, 0, 1'b1, c1);
        run_instr(32'hBFC0_0024, 32'h00A6_2021, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, c2);
        tests++;
        if (c1 !== 3 || c2 !== 3) begin
            fails++;
            $display("FAIL b2b_latency first=%0d second=%0d required 3 and 3", c1, c2);
        end
        tests++;
        if (cpu_data_readdata !== 32'h0A0B_0C0D || cpu_instr_readdata !== 32'h00A6_2021) begin
            fails++;
            $display("FAIL b2b_data data=%h instr=%h required 0a0b0c0d 00a62021",
                     cpu_data_readdata, cpu_instr_readdata);
        end
    endtask

    task automatic test_active_drop();
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (avm_read || cpu_clk_enable) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL active_drop_idle active_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_reset_mid_fetch();
        cpu_instr_address = 32'hBFC0_0100;
        avm_waitrequest = 1'b1;
        cpu_active = 1'b1;
        step();
        step();
        tests++;
        if (avm_read !== 1'b1 || avm_address !== 32'hBFC0_0100) begin
            fails++;
            $display("FAIL midfetch_held rd=%0b addr=%h required 1 bfc00100", avm_read, avm_address);
        end
        reset = 1'b1;
        step();
        tests++;
        if ({avm_read, avm_write, cpu_clk_enable, bus_error} !== 4'b0000 ||
            cpu_instr_readdata !== 32'h0 || cpu_data_readdata !== 32'h0) begin
            fails++;
            $display("FAIL midfetch_reset rd/wr/en/err=%b instr=%h data=%h required 0000 0 0",
                     {avm_read, avm_write, cpu_clk_enable, bus_error}, cpu_instr_readdata, cpu_data_readdata);
        end
        cpu_active = 1'b0;
        avm_waitrequest = 1'b0;
        reset = 1'b0;
        step();
        tests++;
        if (avm_read !== 1'b0) begin
            fails++;
            $display("FAIL midfetch_idle avm_read=%0b required 0", avm_read);
        end
    endtask

`ifdef MIPS_CPU_MEM_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int rd_cycles;
        int bad;
        rd_cycles = 0;
        bad = 0;
        cpu_instr_address = 32'hBFC0_0200;
        avm_waitrequest = 1'b1;
        cpu_active = 1'b1;
        for (int i = 0; i < 20 && !bus_error; i++) begin
            step();
            if (avm_read) rd_cycles++;
        end
        tests++;
        if (rd_cycles !== 4 || bus_error !== 1'b1 || avm_read !== 1'b0) begin
            fails++;
            $display("FAIL timeout_entry rd_cycles=%0d err=%0b rd=%0b required 4 1 0", rd_cycles, bus_error, avm_read);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (cpu_clk_enable || avm_read || avm_write || !bus_error) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL timeout_sticky bad_cycles=%0d required 0", bad);
        end
        reset = 1'b1;
        cpu_active = 1'b0;
        avm_waitrequest = 1'b0;
        step();
        reset = 1'b0;
        tests++;
        if (bus_error !== 1'b0) begin
            fails++;
            $display("FAIL timeout_reset bus_error=%0b required 0", bus_error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_sw();
        test_rw_priority();
        test_fetch_wait();
        test_back_to_back();
        test_active_drop();
        test_reset_mid_fetch();
`ifdef MIPS_CPU_MEM_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        step();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
